sme_sequencer: RTL and testbench
================================

Name: sme_sequencer

Overview:
Sequences the string-matching engine (SME). It accepts string and pattern records from a host byte stream with a valid/ready handshake and buffers each record whole. It then replays the record to SME as back-to-back chardata cycles under isstring/ispattern, waits for SME's valid, and returns match/index plus a status code through a result handshake. It sits between the host command interface and the SME instance and is the only driver of SME's input pins.

Parameters:
STR_MAX, 32, max string length in bytes; the buffer depth equals STR_MAX.
PAT_MAX, 8, max pattern length in bytes.
TIMEOUT, 1024, cycles to wait for sme_valid after the last pattern byte.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  host byte valid.
in_ready  out  1  sequencer can accept a byte.
in_data  in  8  record byte (ASCII).
in_kind  in  1  0 = string record, 1 = pattern record; sampled on the first byte of a record only.
in_last  in  1  marks the final byte of a record.
chardata  out  8  byte to SME.
isstring  out  1  to SME: chardata is a string byte.
ispattern  out  1  to SME: chardata is a pattern byte.
sme_valid  in  1  SME result valid, one-cycle pulse.
sme_match  in  1  SME match flag.
sme_index  in  5  SME match index.
res_valid  out  1  result available.
res_ready  in  1  host accepts result.
res_match  out  1  captured match flag.
res_index  out  5  captured match index.
res_status  out  2  00 ok, 01 timeout, 10 truncated, 11 no string loaded.
busy  out  1  high whenever state is not IDLE.
pat_count  out  16  number of pattern results delivered; wraps modulo 2^16.

Behaviour:
- Reset (reset = 0, async): state IDLE; every output 0 except in_ready = 1; buffer length 0; str_loaded = 0; str_trunc = 0; pat_count = 0.
- A handshake fires when in_valid & in_ready at a posedge. The same rule applies to res_valid & res_ready.
- States are IDLE, LOAD, SEND, WAIT, REPORT. in_ready = 1 only in IDLE and LOAD.
- IDLE: on the first accepted byte, latch kind, store the byte at buf[0], len = 1, trunc = 0.
  - If in_last is also set, go to SEND; otherwise go to LOAD.
- LOAD: each accepted byte is written to buf[len] and len increments.
  - Once len reaches the limit (STR_MAX for a string, PAT_MAX for a pattern), further bytes are accepted but dropped, and trunc is set.
  - in_kind is ignored after the first byte.
  - The in_last handshake moves to SEND on the next cycle.
- SEND: for exactly len consecutive cycles, drive chardata = buf[i] for i = 0..len-1. Hold isstring (string record) or ispattern (pattern record) = 1. All three signals are registered.
  - The flag drops to 0 in the cycle after byte len-1; chardata holds its last value.
- String record: at SEND end set str_loaded = 1 and str_trunc = trunc, then go to IDLE. No result is produced.
- Pattern record with str_loaded = 0: SEND is skipped. Go straight to REPORT with status 11 and res_match = 0, res_index = 0. SME pins stay idle.
- Pattern with a string loaded: after SEND, go to WAIT and clear the timer.
- WAIT: the timer increments each cycle.
  - On sme_valid = 1, capture sme_match/sme_index and go to REPORT.
  - If the timer reaches TIMEOUT-1 without sme_valid, go to REPORT with match = 0, index = 0, status 01.
  - If sme_valid arrives in the same cycle the timer expires, sme_valid wins.
- sme_valid in any state other than WAIT is ignored.
- Status priority: 01 > 10 > 00. Status 10 means the pattern trunc flag or str_trunc is set.
- REPORT: res_valid = 1; res_* are stable until the handshake.
  - On the handshake, pat_count increments and the state returns to IDLE the next cycle, where in_ready = 1.
- Latency: last pattern-byte handshake → first ispattern cycle is 1 cycle. sme_valid → res_valid is 1 cycle.
- Reset mid-operation (any state) aborts immediately. Buffer contents are don't-care after reset; the stored string is forgotten (str_loaded = 0).
- A new string replaces the old one; later patterns match against the latest string.

Test Plan:
- String "hello world", pattern "wor", SME model pulses match = 1, index = 6 → isstring high 11 consecutive cycles, ispattern 3 cycles; res = (1, 6, 00); pat_count = 1.
- Pattern "abc" before any string → no ispattern cycle; res = (0, 0, 11) one cycle after the in_last handshake.
- String, then a 10-byte pattern → only 8 bytes driven; res_status = 10. A 40-byte string gives 32 isstring cycles and status 10 on the following pattern.
- SME model never asserts valid → res = (0, 0, 01) exactly TIMEOUT cycles after entering WAIT. Rerun with sme_valid on the expiry cycle → status 00 with captured values.
- Hold res_ready low for 50 cycles → res_* stable, in_ready = 0, busy = 1. A stray sme_valid during REPORT does not change res_*.
- Assert reset low during SEND of the 5th string byte → outputs cleared asynchronously. A following pattern yields status 11.

Source files
------------

// File: rtl/sme_sequencer.sv
// Host-to-SME sequencer: buffers one string/pattern record, replays it to the
// string-matching engine, then returns match/index/status through a result handshake.
module sme_sequencer #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_kind,
    input  logic        in_last,
    output logic [7:0]  chardata,
    output logic        isstring,
    output logic        ispattern,
    input  logic        sme_valid,
    input  logic        sme_match,
    input  logic [4:0]  sme_index,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_match,
    output logic [4:0]  res_index,
    output logic [1:0]  res_status,
    output logic        busy,
    output logic [15:0] pat_count
);

    localparam int AW = $clog2(STR_MAX);
    localparam int LW = $clog2(STR_MAX + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [LW-1:0] STR_LIM = LW'(STR_MAX);
    localparam logic [LW-1:0] PAT_LIM = LW'(PAT_MAX);
    localparam logic [LW-1:0] ONE_L   = LW'(1);
    localparam logic [TW-1:0] ONE_T   = TW'(1);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_REPORT} state_t;

    state_t         r_state, w_state_next;
    logic [7:0]     r_buf [STR_MAX];
    logic           r_kind, r_trunc, r_str_loaded, r_str_trunc;
    logic [LW-1:0]  r_len, r_idx;
    logic [TW-1:0]  r_timer;
    logic [7:0]     r_chardata;
    logic           r_isstring, r_ispattern;
    logic           r_res_match;
    logic [4:0]     r_res_index;
    logic [1:0]     r_res_status;
    logic [15:0]    r_pat_count;

    logic           w_in_fire, w_res_fire, w_kind, w_room, w_wr, w_no_str;
    logic           w_send_done, w_expire;
    logic [LW-1:0]  w_limit;
    logic [AW-1:0]  w_waddr;
    logic [7:0]     w_first;

    assign in_ready   = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign busy       = (r_state != S_IDLE);
    assign res_valid  = (r_state == S_REPORT);
    assign chardata   = r_chardata;
    assign isstring   = r_isstring;
    assign ispattern  = r_ispattern;
    assign res_match  = r_res_match;
    assign res_index  = r_res_index;
    assign res_status = r_res_status;
    assign pat_count  = r_pat_count;

    assign w_in_fire   = in_valid & in_ready;
    assign w_res_fire  = res_valid & res_ready;
    // in_kind only matters on the first byte; afterwards the latched kind rules.
    assign w_kind      = (r_state == S_IDLE) ? in_kind : r_kind;
    assign w_limit     = w_kind ? PAT_LIM : STR_LIM;
    assign w_room      = (r_state == S_IDLE) || (r_len < w_limit);
    assign w_wr        = w_in_fire & w_room;
    assign w_waddr     = (r_state == S_IDLE) ? '0 : r_len[AW-1:0];
    assign w_no_str    = w_kind & ~r_str_loaded;
    assign w_send_done = (r_idx >= r_len);
    assign w_expire    = (r_timer == T_LAST);
    // A one-byte record has not reached the buffer yet when SEND starts.
    assign w_first     = (r_state == S_IDLE) ? in_data : r_buf[0];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[w_waddr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_in_fire) begin
                    if (!in_last)      w_state_next = S_LOAD;
                    else if (w_no_str) w_state_next = S_REPORT;
                    else               w_state_next = S_SEND;
                end
            end
            S_LOAD: begin
                if (w_in_fire && in_last) w_state_next = w_no_str ? S_REPORT : S_SEND;
            end
            S_SEND: begin
                if (w_send_done) w_state_next = r_kind ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (sme_valid || w_expire) w_state_next = S_REPORT;
            end
            S_REPORT: begin
                if (res_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kind       <= 1'b0;
            r_trunc      <= 1'b0;
            r_str_loaded <= 1'b0;
            r_str_trunc  <= 1'b0;
            r_len        <= '0;
            r_idx        <= '0;
            r_timer      <= '0;
            r_chardata   <= '0;
            r_isstring   <= 1'b0;
            r_ispattern  <= 1'b0;
            r_res_match  <= 1'b0;
            r_res_index  <= '0;
            r_res_status <= '0;
            r_pat_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_in_fire) begin
                        if (r_state == S_IDLE) begin
                            r_kind  <= in_kind;
                            r_len   <= ONE_L;
                            r_trunc <= 1'b0;
                        end else if (w_room) begin
                            r_len <= r_len + ONE_L;
                        end else begin
                            r_trunc <= 1'b1;
                        end
                        // The first replay byte goes out on the cycle after in_last.
                        if (in_last) begin
                            if (w_no_str) begin
                                r_res_match  <= 1'b0;
                                r_res_index  <= '0;
                                r_res_status <= 2'b11;
                            end else begin
                                r_chardata  <= w_first;
                                r_isstring  <= ~w_kind;
                                r_ispattern <= w_kind;
                                r_idx       <= ONE_L;
                            end
                        end
                    end
                end
                S_SEND: begin
                    if (!w_send_done) begin
                        r_chardata <= r_buf[r_idx[AW-1:0]];
                        r_idx      <= r_idx + ONE_L;
                    end else begin
                        r_isstring  <= 1'b0;
                        r_ispattern <= 1'b0;
                        r_timer     <= '0;
                        if (!r_kind) begin
                            r_str_loaded <= 1'b1;
                            r_str_trunc  <= r_trunc;
                        end
                    end
                end
                S_WAIT: begin
                    // A result arriving on the expiry cycle beats the timeout.
                    if (sme_valid) begin
                        r_res_match  <= sme_match;
                        r_res_index  <= sme_index;
                        r_res_status <= (r_trunc || r_str_trunc) ? 2'b10 : 2'b00;
                    end else if (w_expire) begin
                        r_res_match  <= 1'b0;
                        r_res_index  <= '0;
                        r_res_status <= 2'b01;
                    end else begin
                        r_timer <= r_timer + ONE_T;
                    end
                end
                S_REPORT: begin
                    if (w_res_fire) r_pat_count <= r_pat_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sme_sequencer.sv
// Directed bench for sme_sequencer: stimulus pushes expected SME runs and results
// into queues; a negedge monitor models SME and checks what the DUT presents.
module tb_sme_sequencer;
    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_kind = 1'b0;
    logic        in_last = 1'b0;
    logic [7:0]  chardata;
    logic        isstring, ispattern;
    logic        sme_valid = 1'b0;
    logic        sme_match = 1'b0;
    logic [4:0]  sme_index = 5'd0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic        res_match;
    logic [4:0]  res_index;
    logic [1:0]  res_status;
    logic        busy;
    logic [15:0] pat_count;

    sme_sequencer #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_kind(in_kind), .in_last(in_last),
        .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
        .sme_valid(sme_valid), .sme_match(sme_match), .sme_index(sme_index),
        .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
        .res_index(res_index), .res_status(res_status),
        .busy(busy), .pat_count(pat_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {bit m; bit [4:0] idx; bit [1:0] st; int lat_kind; int lat;} res_t;
    typedef struct {bit kind; int len;} run_t;

    res_t sb[$];
    run_t run_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   hs_cyc = 0;
    int   rise_cyc = 0;
    int   sme_delay = -1;
    bit   sme_m = 1'b0;
    bit [4:0] sme_i = 5'd0;
    bit   stray = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_res(input bit m, input int i, input int st, input int lk, input int l);
        res_t r;
        r.m = m; r.idx = 5'(i); r.st = 2'(st); r.lat_kind = lk; r.lat = l;
        sb.push_back(r);
    endtask

    task automatic exp_run(input bit k, input int len);
        run_t e;
        e.kind = k; e.len = len;
        run_q.push_back(e);
    endtask

    // Monitor + SME model; lat_kind 1 = cycles after ispattern fell, 2 = same cycle count as last handshake.
    bit   prev_flag = 1'b0, prev_kind = 1'b0, waiting = 1'b0, res_seen = 1'b0;
    int   run_cnt = 0, fall_cnt = 0;
    res_t mr;
    run_t me;
    always @(negedge clk) begin
        if (!reset) begin
            prev_flag = 1'b0; run_cnt = 0; waiting = 1'b0; res_seen = 1'b0; sme_valid = 1'b0;
        end else begin
            sme_valid = 1'b0;
            if (isstring || ispattern) begin
                if (!prev_flag) rise_cyc = cyc;
                run_cnt++;
                prev_kind = ispattern;
            end else if (prev_flag) begin
                if (run_q.size() == 0) chk("unexpected_run", run_cnt, 0);
                else begin
                    me = run_q.pop_front();
                    chk("run_len", run_cnt, me.len);
                    chk("run_kind", int'(prev_kind), int'(me.kind));
                end
                if (prev_kind) begin waiting = 1'b1; fall_cnt = 0; end
                run_cnt = 0;
            end else if (waiting) fall_cnt++;
            prev_flag = isstring || ispattern;
            if (waiting && fall_cnt == sme_delay) begin
                sme_valid = 1'b1; sme_match = sme_m; sme_index = sme_i;
            end
            if (stray) begin
                sme_valid = 1'b1; sme_match = 1'b0; sme_index = 5'd31;
            end
            if (res_valid && !res_seen) begin
                res_seen = 1'b1;
                if (sb.size() == 0) chk("unexpected_res", int'(res_valid), 0);
                else begin
                    mr = sb.pop_front();
                    $display("result: match=%0d index=%0d status=%0d (expected %0d/%0d/%0d)",
                             res_match, res_index, res_status, mr.m, mr.idx, mr.st);
                    chk("res_match", int'(res_match), int'(mr.m));
                    chk("res_index", int'(res_index), int'(mr.idx));
                    chk("res_status", int'(res_status), int'(mr.st));
                    if (mr.lat_kind == 1) chk("res_lat_wait", fall_cnt, mr.lat);
                    if (mr.lat_kind == 2) chk("res_lat_hs", cyc, hs_cyc);
                end
                waiting = 1'b0;
            end
            if (!res_valid) res_seen = 1'b0;
        end
    end

    task automatic send_rec(input string s, input bit kind);
        for (int i = 0; i < s.len(); i++) begin
            int g = 0;
            @(negedge clk);
            while (!in_ready && g < 2000) begin @(negedge clk); g++; end
            if (g >= 2000) chk("in_ready_wait", int'(in_ready), 1);
            in_valid = 1'b1; in_data = s[i]; in_kind = kind; in_last = (i == s.len() - 1);
            @(posedge clk);
            #1;
            if (in_last) hs_cyc = cyc;
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk); #1;
        while ((busy || sb.size() != 0 || run_q.size() != 0) && g < 3000) begin
            @(negedge clk); #1; g++;
        end
        if (g >= 3000) chk("idle_timeout", g, 0);
    endtask

    task automatic pattern(input string p, input int d, input bit m, input int i);
        sme_delay = d; sme_m = m; sme_i = 5'(i);
        send_rec(p, 1'b1);
        wait_idle();
    endtask

    initial begin
        string s40;
        bit    found;
        s40 = "";
        for (int i = 0; i < 40; i++) s40 = {s40, "q"};

        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk); #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_pat_count", int'(pat_count), 0);
        chk("rst_isstring", int'(isstring), 0);
        chk("rst_chardata", int'(chardata), 0);

        // Pattern before any string: immediate status 11, no SME traffic.
        exp_res(1'b0, 0, 3, 2, 0);
        pattern("abc", -1, 1'b0, 0);
        chk("pc_nostr", int'(pat_count), 1);

        exp_run(1'b0, 11);
        send_rec("hello world", 1'b0);
        wait_idle();
        chk("iss_first_lat", rise_cyc, hs_cyc);
        exp_run(1'b1, 3);
        exp_res(1'b1, 6, 0, 0, 0);
        pattern("wor", 2, 1'b1, 6);
        chk("isp_first_lat", rise_cyc, hs_cyc);
        chk("pc_wor", int'(pat_count), 2);

        // Truncated pattern and truncated string.
        exp_run(1'b1, 8);
        exp_res(1'b0, 0, 2, 0, 0);
        pattern("abcdefghij", 0, 1'b0, 0);
        chk("pc_ptrunc", int'(pat_count), 3);
        exp_run(1'b0, 32);
        send_rec(s40, 1'b0);
        wait_idle();
        exp_run(1'b1, 3);
        exp_res(1'b1, 3, 2, 0, 0);
        pattern("xyz", 1, 1'b1, 3);
        chk("pc_strunc", int'(pat_count), 4);

        // Timeout, then sme_valid exactly on the expiry cycle.
        exp_run(1'b0, 11);
        send_rec("hello world", 1'b0);
        wait_idle();
        exp_run(1'b1, 2);
        exp_res(1'b0, 0, 1, 1, TIMEOUT);
        pattern("lo", -1, 1'b0, 0);
        exp_run(1'b1, 2);
        exp_res(1'b1, 6, 0, 1, TIMEOUT);
        pattern("wo", TIMEOUT - 1, 1'b1, 6);
        chk("pc_timeout", int'(pat_count), 6);

        // Result back-pressure with a stray sme_valid during REPORT.
        res_ready = 1'b0;
        exp_run(1'b1, 2);
        exp_res(1'b1, 7, 0, 0, 0);
        sme_delay = 3; sme_m = 1'b1; sme_i = 5'd7;
        send_rec("or", 1'b1);
        found = 1'b0;
        for (int g = 0; g < 100 && !found; g++) begin
            @(negedge clk); #1;
            found = res_valid;
        end
        chk("stall_res_seen", int'(found), 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            chk("stall_res_valid", int'(res_valid), 1);
            chk("stall_match", int'(res_match), 1);
            chk("stall_index", int'(res_index), 7);
            chk("stall_status", int'(res_status), 0);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_busy", int'(busy), 1);
            chk("stall_pc", int'(pat_count), 6);
            stray = (i == 10);
        end
        stray = 1'b0;
        res_ready = 1'b1;
        wait_idle();
        chk("pc_stall", int'(pat_count), 7);

        // Asynchronous reset while the 5th string byte is on chardata.
        exp_run(1'b0, 11);
        send_rec("abcdefghijk", 1'b0);
        found = 1'b0;
        for (int g = 0; g < 100 && !found; g++) begin
            @(negedge clk);
            found = isstring && (chardata == 8'h65);
        end
        chk("reset_trigger", int'(found), 1);
        #1 reset = 1'b0;
        run_q.delete();
        #1;
        chk("arst_isstring", int'(isstring), 0);
        chk("arst_chardata", int'(chardata), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_busy", int'(busy), 0);
        chk("arst_pat_count", int'(pat_count), 0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        exp_res(1'b0, 0, 3, 2, 0);
        pattern("abc", 0, 1'b0, 0);
        chk("pc_after_reset", int'(pat_count), 1);

        chk("sb_left", sb.size(), 0);
        chk("run_left", run_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
